mac_array_pipe: RTL



---
 rtl/mac_pkg.sv | 34 +++
 rtl/mac_row_pipe.sv | 46 ++++
 rtl/mac_array_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared widths, sideband bundle and arithmetic helpers for the CONV MAC array.
package mac_pkg;
  localparam int DW_D     = 8;
  localparam int WW_D     = 8;
  localparam int CW_D     = 19;
  localparam int OW_D     = 22;
  localparam int ROW_D    = 8;
  localparam int COLUMN_D = 6;
  localparam int LAT_D    = ROW_D + 1;

  typedef struct packed {
    logic first;
    logic last;
    logic valid;
  } sb_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Clamp a sign-extended accumulator into the signed range of an ow-bit result.
  function automatic logic signed [63:0] sat_cw_to_ow(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/mac_row_pipe.sv
// One reduction row: COLUMN PEs sharing one activation, stationary weights, stalled psum register.
module mac_row_pipe import mac_pkg::*; #(
  parameter int DW     = DW_D,
  parameter int WW     = WW_D,
  parameter int CW     = CW_D,
  parameter int COLUMN = COLUMN_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     w_we,
  input  logic [COLUMN*WW-1:0]     w_data,
  input  logic signed [DW-1:0]     x,
  input  logic [COLUMN*CW-1:0]     psum_in,
  input  sb_t                      sb_in,
  output logic [COLUMN*CW-1:0]     psum_out,
  output sb_t                      sb_out
);
  logic [COLUMN*WW-1:0] w_q;
  logic [COLUMN*CW-1:0] psum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       w_q <= '0;
    else if (w_we) w_q <= w_data;
  end

  for (genvar c = 0; c < COLUMN; c++) begin : g_pe
    logic signed [WW-1:0]    wc;
    logic signed [DW+WW-1:0] prod;
    logic signed [CW-1:0]    prod_ext;
    assign wc       = w_q[c*WW +: WW];
    assign prod     = x * wc;
    assign prod_ext = prod;
    assign psum_d[c*CW +: CW] = psum_in[c*CW +: CW] + prod_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum_out <= '0;
      sb_out   <= '0;
    end else if (adv) begin
      psum_out <= psum_d;
      sb_out   <= sb_in;
    end
  end
endmodule

// File: rtl/mac_array_pipe.sv
// Weight-stationary signed MAC array with valid/ready stall; output saturation under MAC_SAT_EN.
module mac_array_pipe import mac_pkg::*; #(
  parameter int DW     = DW_D,
  parameter int WW     = WW_D,
  parameter int CW     = CW_D,
  parameter int OW     = OW_D,
  parameter int ROW    = ROW_D,
  parameter int COLUMN = COLUMN_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLUMN*WW-1:0]   w_data,
  input  logic                   w_load,
  output logic                   w_ready,
  output logic                   w_done,
  input  logic [COLUMN*CW-1:0]   ci,
  input  logic [ROW*DW-1:0]      mac_m_data,
  input  logic                   mac_m_first,
  input  logic                   mac_m_last,
  input  logic                   mac_m_valid,
  output logic                   mac_m_ready,
  output logic [COLUMN*OW-1:0]   mac_s_data,
  output logic                   mac_s_first,
  output logic                   mac_s_last,
`ifdef MAC_SAT_EN
  output logic                   sat_flag,
`endif
  output logic                   mac_s_valid,
  input  logic                   mac_s_ready
);
  localparam int LAT  = ROW + 1;
  localparam int CNTW = (ROW > 1) ? clog2(ROW) : 1;

  logic                      adv, pipe_busy, w_fire;
  logic [CNTW-1:0]           wcnt;
  logic [ROW*DW-1:0]         x_q;
  logic [COLUMN*CW-1:0]      ci_q;
  sb_t                       sb_in_q;
  sb_t [LAT:0]               sb_pipe;
  logic [ROW:0][COLUMN*CW-1:0] psum;
  logic [ROW-1:0][DW-1:0]    x_row;

  assign adv         = ~mac_s_valid | mac_s_ready;
  assign mac_m_ready = adv;

  assign sb_pipe[0] = '{first: mac_m_first, last: mac_m_last, valid: mac_m_valid};
  assign sb_pipe[1] = sb_in_q;
  assign psum[0]    = ci_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      ci_q    <= '0;
      sb_in_q <= '0;
    end else if (adv) begin
      x_q     <= mac_m_data;
      ci_q    <= ci;
      sb_in_q <= sb_pipe[0];
    end
  end

  // Activation r must meet its beat's partial sum at row r, so it waits r extra stages.
  assign x_row[0] = x_q[0 +: DW];
  for (genvar r = 1; r < ROW; r++) begin : g_skew
    logic [DW-1:0] chain [r];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < r; i++) chain[i] <= '0;
      end else if (adv) begin
        chain[0] <= x_q[r*DW +: DW];
        for (int i = 1; i < r; i++) chain[i] <= chain[i-1];
      end
    end
    assign x_row[r] = chain[r-1];
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 1; i <= LAT; i++) pipe_busy = pipe_busy | sb_pipe[i].valid;
  end

  // Weights may only change with nothing in flight, so a pending beat beats a pending load.
  assign w_ready = ~pipe_busy & ~mac_m_valid;
  assign w_fire  = w_load & w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt   <= '0;
      w_done <= 1'b0;
    end else begin
      w_done <= w_fire && (wcnt == CNTW'(ROW - 1));
      if (w_fire) wcnt <= (wcnt == CNTW'(ROW - 1)) ? '0 : wcnt + 1'b1;
    end
  end

  for (genvar r = 0; r < ROW; r++) begin : g_row
    mac_row_pipe #(.DW(DW), .WW(WW), .CW(CW), .COLUMN(COLUMN)) u_row (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .w_we     (w_fire && (wcnt == CNTW'(r))),
      .w_data   (w_data),
      .x        (x_row[r]),
      .psum_in  (psum[r]),
      .sb_in    (sb_pipe[r+1]),
      .psum_out (psum[r+1]),
      .sb_out   (sb_pipe[r+2])
    );
  end

  assign mac_s_valid = sb_pipe[LAT].valid;
  assign mac_s_first = sb_pipe[LAT].first;
  assign mac_s_last  = sb_pipe[LAT].last;

`ifdef MAC_SAT_EN
  logic [COLUMN-1:0] sat_hit;
  for (genvar c = 0; c < COLUMN; c++) begin : g_out
    logic signed [CW-1:0] p;
    logic signed [63:0]   v, s;
    assign p = psum[ROW][c*CW +: CW];
    assign v = p;
    assign s = sat_cw_to_ow(v, OW);
    assign sat_hit[c] = (s != v);
    assign mac_s_data[c*OW +: OW] = s[OW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_flag <= 1'b0;
    else if (mac_s_valid && (|sat_hit)) sat_flag <= 1'b1;
  end
`else
  if (OW < CW) begin : g_ow_err
    $error("mac_array_pipe: OW must be >= CW unless MAC_SAT_EN is defined");
  end
  for (genvar c = 0; c < COLUMN; c++) begin : g_out
    logic signed [CW-1:0] p;
    logic signed [OW-1:0] e;
    assign p = psum[ROW][c*CW +: CW];
    assign e = p;
    assign mac_s_data[c*OW +: OW] = e;
  end
`endif
endmodule
